// File: rtl/i2s_tx_frame_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_frame_serializer
//
// Buffers 24-bit L/R sample pairs from the interpolating FIR path in a small
// FIFO and serialises them as a Philips I2S stream. BCK and WS run free from
// AMCLK_i. An optional 2x decimation keeps every other incoming pair. The
// sticky underrun/overflow flags are exported.
//
// Build option:
//   I2S_TX_UNDERRUN_MUTE_EN  defined     : an underrun frame plays silence
//                            not defined : an underrun frame repeats the last pair
//
// Ports:
//   AMCLK_i          in   audio master clock, sole clock
//   reset_n          in   asynchronous active-low reset (release synchronised upstream)
//   APSDATA_LEFT_i   in   left sample, two's complement
//   APSDATA_RIGHT_i  in   right sample, two's complement
//   APDATA_VALID_i   in   1-cycle strobe, pair on the data inputs is valid
//   downsample_2x    in   1 = accept only every 2nd strobe
//   clr_status_i     in   1-cycle pulse, clears the sticky flags
//   I2S_BCK          out  bit clock
//   I2S_WS           out  word select, 0 = left
//   I2S_DATA         out  serial data, MSB first
//   fifo_level_o     out  current FIFO occupancy
//   underrun_o       out  sticky: a frame started with the FIFO empty
//   overflow_o       out  sticky: a strobe arrived with the FIFO full
// ---------------------------------------------------------------------------
module i2s_tx_frame_serializer #(
    parameter int BCK_DIV    = 4,
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        AMCLK_i,
    input  logic                        reset_n,
    input  logic [DATA_W-1:0]           APSDATA_LEFT_i,
    input  logic [DATA_W-1:0]           APSDATA_RIGHT_i,
    input  logic                        APDATA_VALID_i,
    input  logic                        downsample_2x,
    input  logic                        clr_status_i,
    output logic                        I2S_BCK,
    output logic                        I2S_WS,
    output logic                        I2S_DATA,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        underrun_o,
    output logic                        overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(BCK_DIV);
    localparam int BW = $clog2(2*SLOT_W);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV-1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV/2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT_W-1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);
    localparam logic [BW-1:0] DATA_LEN = BW'(DATA_W);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

    // Timing state
    logic [DW-1:0] div_q, div_nxt;
    logic [BW-1:0] bit_q, bit_nxt, k_nxt;
    logic          div_wrap, frame_wrap, in_right, emit;

    // Output registers
    logic bck_q, ws_q, data_q;

    // Sample path
    logic [DATA_W-1:0] l_sh, r_sh, hold_l, hold_r;

    // FIFO
    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [2*DATA_W-1:0] head;
    logic [AW:0]         wr_cnt, rd_cnt, level;
    logic                empty, full, pop, push, accept, phase_q;
    logic                ovf_set, unf_set, underrun_q, overflow_q;

    // Everything is evaluated for the "next" bit position, so the registered
    // outputs move together on the cycle BCK falls (divider wrap).
    always_comb begin
        div_wrap   = (div_q == DIV_LAST);
        frame_wrap = div_wrap && (bit_q == BIT_LAST);
        div_nxt    = div_wrap ? '0 : div_q + 1'b1;
        if (frame_wrap)
            bit_nxt = '0;
        else if (div_wrap)
            bit_nxt = bit_q + 1'b1;
        else
            bit_nxt = bit_q;
        in_right = (bit_nxt >= SLOT_LEN);
        k_nxt    = in_right ? bit_nxt - SLOT_LEN : bit_nxt;
        // Slot bit 0 is the one-BCK Philips delay; bits past DATA_W are padding.
        emit     = (k_nxt != '0) && (k_nxt <= DATA_LEN);
    end

    always_comb begin
        level   = wr_cnt - rd_cnt;
        empty   = (level == '0);
        full    = (level == FULL_LVL);
        head    = mem[rd_cnt[AW-1:0]];
        pop     = frame_wrap && !empty;
        accept  = APDATA_VALID_i && (!downsample_2x || !phase_q);
        // A pop in the same cycle frees the slot being written, so a full
        // FIFO still takes the new pair then.
        push    = accept && (!full || pop);
        ovf_set = accept && full && !pop;
        unf_set = frame_wrap && empty;
    end

    always_ff @(posedge AMCLK_i) begin
        if (push)
            mem[wr_cnt[AW-1:0]] <= {APSDATA_LEFT_i, APSDATA_RIGHT_i};
    end

    always_ff @(posedge AMCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            bit_q      <= '0;
            bck_q      <= 1'b0;
            ws_q       <= 1'b0;
            data_q     <= 1'b0;
            l_sh       <= '0;
            r_sh       <= '0;
            hold_l     <= '0;
            hold_r     <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            phase_q    <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_q <= div_nxt;
            bit_q <= bit_nxt;
            bck_q <= (div_nxt >= DIV_HALF);

            if (div_wrap) begin
                ws_q   <= in_right;
                data_q <= emit ? (in_right ? r_sh[DATA_W-1] : l_sh[DATA_W-1]) : 1'b0;
            end

            // The load coincides with slot bit 0, which never shifts.
            if (pop) begin
                l_sh   <= head[2*DATA_W-1:DATA_W];
                r_sh   <= head[DATA_W-1:0];
                hold_l <= head[2*DATA_W-1:DATA_W];
                hold_r <= head[DATA_W-1:0];
            end else if (frame_wrap) begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
                l_sh   <= '0;
                r_sh   <= '0;
                hold_l <= '0;
                hold_r <= '0;
`else
                l_sh   <= hold_l;
                r_sh   <= hold_r;
`endif
            end else if (div_wrap && emit) begin
                if (in_right)
                    r_sh <= r_sh << 1;
                else
                    l_sh <= l_sh << 1;
            end

            if (push)
                wr_cnt <= wr_cnt + 1'b1;
            if (pop)
                rd_cnt <= rd_cnt + 1'b1;

            if (!downsample_2x)
                phase_q <= 1'b0;
            else if (APDATA_VALID_i)
                phase_q <= ~phase_q;

            // Set beats clear when both happen in one cycle.
            underrun_q <= unf_set | (underrun_q & ~clr_status_i);
            overflow_q <= ovf_set | (overflow_q & ~clr_status_i);
        end
    end

    assign I2S_BCK      = bck_q;
    assign I2S_WS       = ws_q;
    assign I2S_DATA     = data_q;
    assign fifo_level_o = level;
    assign underrun_o   = underrun_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_i2s_tx_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_frame_serializer
//
// Directed bench for i2s_tx_frame_serializer with BCK_DIV=4, DATA_W=24,
// SLOT_W=32, FIFO_DEPTH=4 (frame = 256 AMCLK cycles). Frames are captured
// by sampling I2S_DATA/I2S_WS on every BCK rise after a WS falling edge and
// decoded back into left/right words.
// Honours I2S_TX_UNDERRUN_MUTE_EN for the underrun-repeat expectation.
// ---------------------------------------------------------------------------
module tb_i2s_tx_frame_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] left, right;
    logic        valid, ds, clr;
    logic        bck, ws, sdata, unf, ovf;
    logic [2:0]  level;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    i2s_tx_frame_serializer #(
        .BCK_DIV    (4),
        .DATA_W     (24),
        .SLOT_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .AMCLK_i         (clk),
        .reset_n         (rst_n),
        .APSDATA_LEFT_i  (left),
        .APSDATA_RIGHT_i (right),
        .APDATA_VALID_i  (valid),
        .downsample_2x   (ds),
        .clr_status_i    (clr),
        .I2S_BCK         (bck),
        .I2S_WS          (ws),
        .I2S_DATA        (sdata),
        .fifo_level_o    (level),
        .underrun_o      (unf),
        .overflow_o      (ovf)
    );

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
    } vec_t;

    vec_t vecs [5];

    logic        cap_d  [64];
    logic        cap_ws [64];
    logic [23:0] cap_l, cap_r;
    logic        cap_pad, cap_wsok;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic timeout(input string name, input int n);
        checks++;
        $display("FAIL %s: no event after %0d cycles", name, n);
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        left  = l;
        right = r;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_ws_fall();
        logic prev;
        int   n;
        bit   done;
        prev = ws;
        n    = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (prev && !ws) done = 1;
            else if (n >= 700) begin
                timeout("ws_fall_wait", n);
                done = 1;
            end
            prev = ws;
        end
    endtask

    task automatic wait_bck_rise();
        logic prev;
        int   n;
        bit   done;
        prev = bck;
        n    = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (!prev && bck) done = 1;
            else if (n >= 20) begin
                timeout("bck_rise_wait", n);
                done = 1;
            end
            prev = bck;
        end
    endtask

    task automatic capture_frame();
        wait_ws_fall();
        for (int i = 0; i < 64; i++) begin
            wait_bck_rise();
            cap_d[i]  = sdata;
            cap_ws[i] = ws;
        end
        cap_l    = '0;
        cap_r    = '0;
        cap_pad  = 1'b0;
        cap_wsok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (cap_ws[i] != (i >= 32)) cap_wsok = 1'b0;
            if ((i % 32) == 0 || (i % 32) > 24) cap_pad = cap_pad | cap_d[i];
        end
        for (int j = 0; j < 24; j++) begin
            cap_l[23-j] = cap_d[1+j];
            cap_r[23-j] = cap_d[33+j];
        end
    endtask

    initial begin
        int   n;
        int   nz;
        logic prev;

        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
        vecs[1] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
        vecs[2] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001};
        vecs[3] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        vecs[4] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};

        rst_n = 1'b0;
        left  = '0;
        right = '0;
        valid = 1'b0;
        ds    = 1'b0;
        clr   = 1'b0;

        // ---- reset state and free-running clocks ----
        repeat (3) @(negedge clk);
        chk("rst_bck", bck, 0);
        chk("rst_ws", ws, 0);
        chk("rst_data", sdata, 0);
        chk("rst_level", level, 0);
        chk("rst_underrun", unf, 0);
        chk("rst_overflow", ovf, 0);

        rst_n = 1'b1;
        n  = 0;
        nz = 0;
        while (!ws && n < 1000) begin
            if (sdata) nz++;
            n++;
            @(negedge clk);
        end
        chk("ws_low_cycles_after_reset", n, 128);
        chk("underrun_before_wrap", unf, 0);

        wait_bck_rise();
        n = 0;
        prev = bck;
        while (!(!prev && bck) || n == 0) begin
            prev = bck;
            @(negedge clk);
            n++;
            if (n > 20) break;
        end
        chk("bck_period", n, 4);
        n = 0;
        while (bck && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("bck_high_cycles", n, 2);

        wait_ws_fall();
        chk("underrun_after_first_wrap", unf, 1);
        n = 0;
        prev = ws;
        while (!(prev && !ws) || n == 0) begin
            prev = ws;
            @(negedge clk);
            if (sdata) nz++;
            n++;
            if (n > 700) break;
        end
        chk("ws_period", n, 256);
        chk("data_zero_while_empty", nz, 0);

        pulse_clr();
        chk("underrun_cleared", unf, 0);

        // ---- single pairs through the frame ----
        for (int v = 0; v < 5; v++) begin
            wait_ws_fall();
            push(vecs[v].l, vecs[v].r);
            chk($sformatf("v%0d_level_after_push", v), level, 1);
            capture_frame();
            chk($sformatf("v%0d_left", v), cap_l, vecs[v].exp_l);
            chk($sformatf("v%0d_right", v), cap_r, vecs[v].exp_r);
            chk($sformatf("v%0d_padding", v), cap_pad, 0);
            chk($sformatf("v%0d_ws_pattern", v), cap_wsok, 1);
            chk($sformatf("v%0d_level_after_pop", v), level, 0);
        end

        // ---- 2x decimation: strobes 1..4, only 1 and 3 kept ----
        wait_ws_fall();
        ds = 1'b1;
        for (int i = 1; i <= 4; i++) push(24'(i), 24'(16 * i));
        ds = 1'b0;
        chk("ds_level", level, 2);
        capture_frame();
        chk("ds_frame0_left", cap_l, 24'd1);
        chk("ds_frame0_right", cap_r, 24'd16);
        capture_frame();
        chk("ds_frame1_left", cap_l, 24'd3);
        chk("ds_frame1_right", cap_r, 24'd48);

        // ---- overflow: 6 back-to-back strobes into a depth-4 FIFO ----
        wait_ws_fall();
        chk("ovf_before", ovf, 0);
        for (int i = 1; i <= 6; i++) push(24'(i * 24'h111111), 24'(i));
        chk("ovf_level_full", level, 4);
        chk("ovf_flag", ovf, 1);
        for (int i = 1; i <= 4; i++) begin
            capture_frame();
            chk($sformatf("ovf_frame%0d_left", i), cap_l, 24'(i * 24'h111111));
            chk($sformatf("ovf_frame%0d_right", i), cap_r, 24'(i));
        end
        chk("ovf_level_drained", level, 0);
        pulse_clr();
        chk("ovf_cleared", ovf, 0);

        // ---- starvation after a single pair ----
        wait_ws_fall();
        push(24'h123456, 24'h654321);
        capture_frame();
        chk("starve_first_left", cap_l, 24'h123456);
        pulse_clr();
        chk("starve_underrun_cleared", unf, 0);
        capture_frame();
        chk("starve_underrun_set", unf, 1);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
        chk("starve_repeat_left", cap_l, 24'h000000);
        chk("starve_repeat_right", cap_r, 24'h000000);
`else
        chk("starve_repeat_left", cap_l, 24'h123456);
        chk("starve_repeat_right", cap_r, 24'h654321);
`endif

        // ---- reset in the middle of the right slot ----
        wait_ws_fall();
        push(24'hFEDCBA, 24'h0F0F0F);
        n = 0;
        while (!ws && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("pre_reset_ws", ws, 1);
        chk("pre_reset_level", level, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_bck", bck, 0);
        chk("midrst_ws", ws, 0);
        chk("midrst_data", sdata, 0);
        chk("midrst_level", level, 0);
        chk("midrst_underrun", unf, 0);
        chk("midrst_overflow", ovf, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n  = 0;
        nz = 0;
        while (!ws && n < 1000) begin
            if (sdata) nz++;
            n++;
            @(negedge clk);
        end
        chk("postrst_ws_low_cycles", n, 128);
        chk("postrst_level", level, 0);
        chk("postrst_data_zero", nz, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
